// File: rtl/irq_pkg.sv
// Shared constants and types for the platform interrupt controller:
// register window offsets, gateway states and the interrupt ID width.
package irq_pkg;

  localparam int ID_W = 5;

  localparam logic [11:0] REG_PENDING       = 12'h000;
  localparam logic [11:0] REG_ENABLE        = 12'h004;
  localparam logic [11:0] REG_TRIGGER       = 12'h008;
  localparam logic [11:0] REG_THRESHOLD     = 12'h00C;
  localparam logic [11:0] REG_CLAIM         = 12'h010;
  localparam logic [11:0] REG_PRIORITY_BASE = 12'h100;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PENDING,
    GW_CLAIMED
  } gw_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Register-window bus between software (master) and the interrupt
// controller (slave), in the same addr/wdata/wen/ren/rdata style as the CSR file.
interface irq_controller_if;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wen, output ren, input rdata);
  modport slave  (input addr, input wdata, input wen, input ren, output rdata);
endinterface

// File: rtl/irq_gateway.sv
// Per-source gateway: turns a level or rising-edge request into a pending
// bit and tracks the claim/complete handshake, remembering one edge seen while claimed.
module irq_gateway
  import irq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic trigger,
  input  logic claim,
  input  logic complete,
  output logic pending,
  output logic claimed
);

  gw_state_e state, state_next;
  logic      src_q;
  logic      deferred, deferred_next;
  logic      rise;
  logic      detect;

  assign rise   = src & ~src_q;
  assign detect = trigger ? rise : src;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GW_IDLE;
      src_q    <= 1'b0;
      deferred <= 1'b0;
    end else begin
      state    <= state_next;
      src_q    <= src;
      deferred <= deferred_next;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_next    = state;
    deferred_next = deferred;
    case (state)
      GW_IDLE:    if (detect) state_next = GW_PENDING;
      GW_PENDING: if (claim)  state_next = GW_CLAIMED;
      GW_CLAIMED: begin
        if (complete) begin
          // An edge landing on the completing cycle is still held, like any other deferred edge.
          state_next    = (deferred || (trigger && rise)) ? GW_PENDING : GW_IDLE;
          deferred_next = 1'b0;
        end else if (trigger && rise) begin
          deferred_next = 1'b1;
        end
      end
      default:    state_next = GW_IDLE;
    endcase
  end

  assign pending = (state == GW_PENDING);
  assign claimed = (state == GW_CLAIMED);

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller top: configuration registers, priority/threshold
// arbiter, claim/complete decode and the registered request to the core.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NUM_SOURCES = 8,
  parameter int PRIO_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SOURCES-1:0] src_irq,
  irq_controller_if.slave        bus,
  output logic                   irq_out
);

  logic [NUM_SOURCES-1:0] enable, trigger, pending, claimed, claim, complete;
  logic [PRIO_W-1:0]      threshold;
  logic [PRIO_W-1:0]      prio [NUM_SOURCES];

  logic              wr, rd, prio_hit, win_ok;
  logic [ID_W-1:0]   prio_idx, win_id;
  logic [PRIO_W-1:0] win_prio;
  logic [31:0]       rd_val;
  logic              unused_bits;

  // A simultaneous read and write performs only the write.
  assign wr       = bus.wen;
  assign rd       = bus.ren & ~bus.wen;
  assign prio_idx = bus.addr[ID_W+1:2];
  assign prio_hit = (bus.addr[11:7] == REG_PRIORITY_BASE[11:7]) && (bus.addr[1:0] == 2'b00)
                    && (int'(prio_idx) < NUM_SOURCES);

  for (genvar g = 0; g < NUM_SOURCES; g++) begin : g_gw
    irq_gateway u_gw (
      .clk      (clk),
      .rst      (rst),
      .src      (src_irq[g]),
      .trigger  (trigger[g]),
      .claim    (claim[g]),
      .complete (complete[g]),
      .pending  (pending[g]),
      .claimed  (claimed[g])
    );
  end

  // Strict '>' while scanning upward gives ties to the lowest ID and drops priority-0 sources.
  always_comb begin
    win_id   = '0;
    win_prio = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (pending[i] && enable[i] && (prio[i] > win_prio)) begin
        win_id   = ID_W'(i + 1);
        win_prio = prio[i];
      end
    end
  end

  assign win_ok = (win_id != '0) && (win_prio > threshold);

  always_comb begin
    claim    = '0;
    complete = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      claim[i]    = rd && (bus.addr == REG_CLAIM) && win_ok && (win_id == ID_W'(i + 1));
      complete[i] = wr && (bus.addr == REG_CLAIM) && (bus.wdata[ID_W-1:0] == ID_W'(i + 1));
    end
  end

  always_comb begin
    rd_val = '0;
    if (prio_hit) begin
      for (int i = 0; i < NUM_SOURCES; i++)
        if (prio_idx == ID_W'(i)) rd_val[PRIO_W-1:0] = prio[i];
    end else begin
      case (bus.addr)
        REG_PENDING:   rd_val[NUM_SOURCES-1:0] = pending;
        REG_ENABLE:    rd_val[NUM_SOURCES-1:0] = enable;
        REG_TRIGGER:   rd_val[NUM_SOURCES-1:0] = trigger;
        REG_THRESHOLD: rd_val[PRIO_W-1:0]      = threshold;
        REG_CLAIM:     if (win_ok) rd_val[ID_W-1:0] = win_id;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable    <= '0;
      trigger   <= '0;
      threshold <= '0;
      // NOTE: the priority array is a small register file that software expects to read 0 after reset, so it is reset explicitly.
      for (int i = 0; i < NUM_SOURCES; i++) prio[i] <= '0;
      irq_out   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      irq_out <= win_ok;
      if (bus.ren) bus.rdata <= bus.wen ? '0 : rd_val;
      if (wr) begin
        case (bus.addr)
          REG_ENABLE:    enable    <= bus.wdata[NUM_SOURCES-1:0];
          REG_TRIGGER:   trigger   <= bus.wdata[NUM_SOURCES-1:0];
          REG_THRESHOLD: threshold <= bus.wdata[PRIO_W-1:0];
          default:       ;
        endcase
        for (int i = 0; i < NUM_SOURCES; i++)
          if (prio_hit && (prio_idx == ID_W'(i))) prio[i] <= bus.wdata[PRIO_W-1:0];
      end
    end
  end

  assign unused_bits = ^{bus.wdata[31:NUM_SOURCES], claimed};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: a per-cycle behavioural model of
// the gateways/arbiter plus directed scenarios with hand-computed expectations.
module tb_irq_controller;

  localparam int N = 8;

  localparam logic [11:0] A_PEND  = 12'h000;
  localparam logic [11:0] A_EN    = 12'h004;
  localparam logic [11:0] A_TRIG  = 12'h008;
  localparam logic [11:0] A_THR   = 12'h00C;
  localparam logic [11:0] A_CLAIM = 12'h010;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] src_irq = '0;
  logic         irq_out;

  irq_controller_if bus ();

  irq_controller #(.NUM_SOURCES(N), .PRIO_W(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .src_irq (src_irq),
    .bus     (bus),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Source state: 0 idle, 1 pending, 2 claimed.
  int          st  [N];
  bit          dfr [N];
  bit          ec  [N];
  int          pr  [N];
  logic [31:0] m_en, m_trg;
  int          m_thr;
  logic        exp_irq   = 1'b0;
  logic [31:0] exp_rdata = '0;

  function automatic int win_id();
    int best = 0;
    int bp   = 0;
    for (int i = 0; i < N; i++)
      if (st[i] == 1 && m_en[i] && pr[i] > bp) begin
        bp   = pr[i];
        best = i + 1;
      end
    return best;
  endfunction

  function automatic bit win_ok();
    int id = win_id();
    return (id != 0) && (pr[id-1] > m_thr);
  endfunction

  function automatic logic [31:0] model_read(logic [11:0] a);
    logic [31:0] v = '0;
    if (a >= 12'h100 && int'(a) < 'h100 + 4 * N && a[1:0] == 2'b00)
      return 32'(pr[(int'(a) - 'h100) / 4]);
    case (a)
      A_PEND:  for (int i = 0; i < N; i++) v[i] = (st[i] == 1);
      A_EN:    v = m_en;
      A_TRIG:  v = m_trg;
      A_THR:   v = 32'(m_thr);
      A_CLAIM: v = win_ok() ? 32'(win_id()) : 32'd0;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_step();
    int w, cid;
    bit ok, rd_en, do_cmp, rise, det;
    int nst [N];
    bit ndf [N];
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        st[i] = 0; dfr[i] = 0; ec[i] = 0; pr[i] = 0;
      end
      m_en = '0; m_trg = '0; m_thr = 0;
      exp_irq = 1'b0; exp_rdata = '0;
      return;
    end
    w      = win_id();
    ok     = win_ok();
    rd_en  = bus.ren && !bus.wen;
    do_cmp = bus.wen && bus.addr == A_CLAIM;
    cid    = int'(bus.wdata[4:0]);
    if (bus.ren) exp_rdata = bus.wen ? 32'd0 : model_read(bus.addr);
    exp_irq = ok;
    for (int i = 0; i < N; i++) begin
      nst[i] = st[i];
      ndf[i] = dfr[i];
      rise   = src_irq[i] && !ec[i];
      det    = m_trg[i] ? rise : src_irq[i];
      if (st[i] == 0) begin
        if (det) nst[i] = 1;
      end else if (st[i] == 1) begin
        if (rd_en && bus.addr == A_CLAIM && ok && w == i + 1) nst[i] = 2;
      end else begin
        if (do_cmp && cid == i + 1) begin
          nst[i] = (dfr[i] || (m_trg[i] && rise)) ? 1 : 0;
          ndf[i] = 0;
        end else if (m_trg[i] && rise) begin
          ndf[i] = 1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      st[i]  = nst[i];
      dfr[i] = ndf[i];
      ec[i]  = src_irq[i];
    end
    if (bus.wen) begin
      case (bus.addr)
        A_EN:    m_en  = bus.wdata & 32'hFF;
        A_TRIG:  m_trg = bus.wdata & 32'hFF;
        A_THR:   m_thr = int'(bus.wdata[2:0]);
        default: ;
      endcase
      if (bus.addr >= 12'h100 && int'(bus.addr) < 'h100 + 4 * N && bus.addr[1:0] == 2'b00)
        pr[(int'(bus.addr) - 'h100) / 4] = int'(bus.wdata[2:0]);
    end
  endtask

  always @(posedge clk or posedge rst) model_step();

  // One compare process: both outputs every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("irq_out_cycle", 32'(irq_out), 32'(exp_irq));
      check("rdata_cycle", bus.rdata, exp_rdata);
    end
  end

  // ---------------- bus helpers (start and end at posedge+1) ----------------
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(logic [11:0] a, logic [31:0] d);
    bus.addr = a; bus.wdata = d; bus.wen = 1'b1;
    tick();
    bus.wen = 1'b0;
  endtask

  task automatic rd_chk(string name, logic [11:0] a, logic [31:0] e);
    bus.addr = a; bus.ren = 1'b1;
    tick();
    bus.ren = 1'b0;
    check(name, bus.rdata, e);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    bus.addr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.ren = 1'b0;
    tick(3);
    rst = 1'b0;
    check("reset_irq_out", 32'(irq_out), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    rd_chk("reset_enable", A_EN, 32'd0);
    rd_chk("reset_prio2", 12'h108, 32'd0);

    // Level source 2 (ID 3), priority 5.
    wr(12'h108, 32'd5);
    wr(A_EN, 32'h4);
    wr(A_THR, 32'd0);
    src_irq[2] = 1'b1;
    tick();
    check("lvl_irq_after_1", 32'(irq_out), 32'd0);
    tick();
    check("lvl_irq_after_2", 32'(irq_out), 32'd1);
    rd_chk("lvl_pending", A_PEND, 32'h4);
    rd_chk("lvl_claim", A_CLAIM, 32'd3);
    rd_chk("lvl_pending_claimed", A_PEND, 32'h0);
    wr(A_CLAIM, 32'd3);
    tick();
    rd_chk("lvl_repend", A_PEND, 32'h4);
    src_irq[2] = 1'b0;
    rd_chk("lvl_claim2", A_CLAIM, 32'd3);
    wr(A_CLAIM, 32'd3);

    // Priority tie-break, then raise source 1.
    wr(A_EN, 32'h3);
    wr(12'h100, 32'd4);
    wr(12'h104, 32'd4);
    src_irq[1:0] = 2'b11;
    tick(2);
    rd_chk("tie_claim", A_CLAIM, 32'd1);
    wr(A_CLAIM, 32'd1);
    tick();
    wr(12'h104, 32'd6);
    rd_chk("raised_claim", A_CLAIM, 32'd2);
    tick();
    check("no_gap_irq", 32'(irq_out), 32'd1);
    rd_chk("second_claim", A_CLAIM, 32'd1);
    src_irq[1:0] = 2'b00;
    wr(A_CLAIM, 32'd1);
    wr(A_CLAIM, 32'd2);

    // Threshold blocking at equal priority.
    wr(12'h10C, 32'd4);
    wr(A_EN, 32'h8);
    wr(A_THR, 32'd4);
    src_irq[3] = 1'b1;
    tick(3);
    check("thr_block_irq", 32'(irq_out), 32'd0);
    rd_chk("thr_block_claim", A_CLAIM, 32'd0);
    wr(A_THR, 32'd3);
    check("thr_irq_same_cycle", 32'(irq_out), 32'd0);
    tick();
    check("thr_irq_next", 32'(irq_out), 32'd1);
    src_irq[3] = 1'b0;
    rd_chk("thr_claim", A_CLAIM, 32'd4);
    wr(A_CLAIM, 32'd4);
    wr(A_THR, 32'd0);

    // Edge source 4 (ID 5): three edges while claimed collapse to one.
    wr(A_TRIG, 32'h10);
    wr(12'h110, 32'd2);
    wr(A_EN, 32'h10);
    src_irq[4] = 1'b1; tick(); src_irq[4] = 1'b0;
    tick(2);
    check("edge_irq", 32'(irq_out), 32'd1);
    rd_chk("edge_claim", A_CLAIM, 32'd5);
    for (int k = 0; k < 3; k++) begin
      src_irq[4] = 1'b1; tick();
      src_irq[4] = 1'b0; tick();
    end
    rd_chk("edge_pending_claimed", A_PEND, 32'h0);
    wr(A_CLAIM, 32'd5);
    rd_chk("edge_deferred_pend", A_PEND, 32'h10);
    rd_chk("edge_claim2", A_CLAIM, 32'd5);
    wr(A_CLAIM, 32'd5);
    tick();
    rd_chk("edge_idle_pend", A_PEND, 32'h0);
    rd_chk("edge_idle_claim", A_CLAIM, 32'd0);
    check("edge_idle_irq", 32'(irq_out), 32'd0);

    // Illegal completes and simultaneous read/write.
    src_irq[4] = 1'b1; tick(); src_irq[4] = 1'b0;
    tick(2);
    rd_chk("ill_claim", A_CLAIM, 32'd5);
    src_irq[4] = 1'b1; tick(); src_irq[4] = 1'b0;
    wr(A_CLAIM, 32'd0);
    wr(A_CLAIM, 32'd9);
    wr(A_CLAIM, 32'd2);
    rd_chk("ill_still_claimed", A_PEND, 32'h0);
    wr(A_CLAIM, 32'd5);
    bus.addr = A_CLAIM; bus.wdata = 32'd0; bus.wen = 1'b1; bus.ren = 1'b1;
    tick();
    bus.wen = 1'b0; bus.ren = 1'b0;
    check("rw_rdata_zero", bus.rdata, 32'd0);
    rd_chk("rw_no_claim", A_PEND, 32'h10);
    rd_chk("rw_claim_after", A_CLAIM, 32'd5);

    // Asynchronous reset while ID 5 claimed and ID 3 requesting.
    wr(A_EN, 32'h14);
    src_irq[2] = 1'b1;
    tick(2);
    check("pre_rst_irq", 32'(irq_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_irq_out", 32'(irq_out), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_chk("post_rst_enable", A_EN, 32'd0);
    rd_chk("post_rst_prio2", 12'h108, 32'd0);
    rd_chk("post_rst_thr", A_THR, 32'd0);
    rd_chk("post_rst_trig", A_TRIG, 32'd0);
    check("post_rst_irq", 32'(irq_out), 32'd0);
    src_irq = '0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
